// File: rtl/alu_sequencer_fsm_if.sv
// Instruction handshake and ALU operand/result bus of the ALU sequencer.
//
// Handshake: an instruction transfers on a rising clock edge where
// instr_valid && instr_ready are both high. instr_ready depends only on the
// sequencer state, never on instr_valid. An instruction offered while
// instr_ready is low is neither consumed nor remembered; the source keeps it
// on the bus until it is taken.
//
// master: the sequencer. It accepts instructions and is the initiator
// towards the combinational ALU.
// slave: the environment. It supplies instructions and the ALU result.
interface alu_sequencer_fsm_if;
  logic [19:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_opA;
  logic [7:0]  alu_opB;
  logic [15:0] alu_result;

  modport master (
    input  instr, instr_valid, alu_result,
    output instr_ready, alu_opcode, alu_opA, alu_opB
  );

  modport slave (
    output instr, instr_valid, alu_result,
    input  instr_ready, alu_opcode, alu_opA, alu_opB
  );
endinterface

// File: rtl/alu_sequencer_fsm.sv
// Multi-cycle sequencer for the 16-bit combinational ALU core.
// Each instruction takes IDLE -> DECODE -> EXECUTE -> WRITEBACK and then
// returns to IDLE, giving one instruction every four cycles. Operands come
// from a 4 x 8-bit register file or from an immediate. HALT parks the
// sequencer until reset.
module alu_sequencer_fsm #(
  parameter logic [3:0] HALT_OPCODE = 4'b1111,
  parameter int         COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  alu_sequencer_fsm_if.master    bus,
  input  logic                   load_en,
  input  logic [1:0]             load_addr,
  input  logic [7:0]             load_data,
  output logic [15:0]            result_out,
  output logic                   result_valid,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] instr_count,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    HALTED    = 3'd4
  } state_t;

  state_t      state, state_nxt;

  // Latched instruction fields. Bit 8 of the instruction word is reserved
  // and is not stored.
  logic [3:0]  op_r;
  logic [1:0]  rd_r, ra_r, rb_r;
  logic        imm_sel_r;
  logic [7:0]  imm_r;

  logic [7:0]  rf [4];
  logic [15:0] result_r;
  logic [3:0]  alu_opcode_r;
  logic [7:0]  alu_opa_r, alu_opb_r;
  logic        accept;
  logic        unused_reserved;

  assign accept          = (state == IDLE) && bus.instr_valid;
  assign unused_reserved = bus.instr[8];

  assign bus.instr_ready = (state == IDLE);
  assign bus.alu_opcode  = alu_opcode_r;
  assign bus.alu_opA     = alu_opa_r;
  assign bus.alu_opB     = alu_opb_r;
  assign halted          = (state == HALTED);
  assign state_dbg       = state;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; HALTED is only left through reset.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.instr[19:16] == HALT_OPCODE) state_nxt = HALTED;
          else                                 state_nxt = DECODE;
        end
      end
      DECODE:    state_nxt = EXECUTE;
      EXECUTE:   state_nxt = WRITEBACK;
      WRITEBACK: state_nxt = IDLE;
      HALTED:    state_nxt = HALTED;
      default:   state_nxt = IDLE;
    endcase
  end

  // Datapath: preload and latch in IDLE, present operands in DECODE,
  // capture the ALU result in EXECUTE, write it back in WRITEBACK.
  // Writeback is at least two edges ahead of the next DECODE read, so the
  // register file needs no forwarding path.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
      op_r         <= 4'h0;
      rd_r         <= 2'd0;
      ra_r         <= 2'd0;
      rb_r         <= 2'd0;
      imm_sel_r    <= 1'b0;
      imm_r        <= 8'h00;
      result_r     <= 16'h0000;
      alu_opcode_r <= 4'h0;
      alu_opa_r    <= 8'h00;
      alu_opb_r    <= 8'h00;
      result_out   <= 16'h0000;
      result_valid <= 1'b0;
      instr_count  <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load_en) rf[load_addr] <= load_data;
          if (accept) begin
            op_r      <= bus.instr[19:16];
            rd_r      <= bus.instr[15:14];
            ra_r      <= bus.instr[13:12];
            rb_r      <= bus.instr[11:10];
            imm_sel_r <= bus.instr[9];
            imm_r     <= bus.instr[7:0];
          end
        end
        DECODE: begin
          alu_opcode_r <= op_r;
          alu_opa_r    <= rf[ra_r];
          alu_opb_r    <= imm_sel_r ? imm_r : rf[rb_r];
        end
        EXECUTE: begin
          result_r <= bus.alu_result;
        end
        WRITEBACK: begin
          rf[rd_r]     <= result_r[7:0];
          result_out   <= result_r;
          result_valid <= 1'b1;
          instr_count  <= instr_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
